// File: rtl/pokey_poly_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pokey_poly_pkg
// Brief    : Default POKEY poly constants and parameter sanity helpers.
// Revision : 1.0
// ============================================================================
package pokey_poly_pkg;

    typedef enum logic {
        MODE_FULL  = 1'b0,
        MODE_SHORT = 1'b1
    } poly_mode_e;

    localparam int         POLY4_LEN   = 4;
    localparam int         POLY4_TAP   = 1;
    localparam logic [3:0] POLY4_SEED  = 4'b1010;

    localparam int         POLY5_LEN   = 5;
    localparam int         POLY5_TAP   = 2;
    localparam logic [4:0] POLY5_SEED  = 5'b01010;

    localparam int          POLY17_LEN       = 17;
    localparam int          POLY17_TAP       = 5;
    localparam int          POLY17_SHORT_LEN = 9;
    localparam int          POLY17_SHORT_TAP = 4;
    localparam logic [16:0] POLY17_SEED      = 17'h0AAAA;
    localparam int          POLY_RAND_W      = 8;

    // An all-ones seed is the XNOR lock-up state, so it is rejected at elaboration.
    function automatic bit seed_ok(input logic [63:0] seed, input int unsigned len);
        logic [63:0] mask;
        mask = (64'd1 << len) - 64'd1;
        return (seed & mask) != mask;
    endfunction

    function automatic bit shape_ok(input int len, input int tap, input int short_en,
                                    input int short_len, input int short_tap,
                                    input int rand_w);
        bit ok;
        ok = (len >= 4) && (len <= 32) && (tap >= 1) && (tap < len) && (rand_w >= 1);
        if (short_en != 0) begin
            ok = ok && (short_len >= 2) && (short_len < len) && (short_tap < short_len - 1)
                    && (rand_w <= short_len);
        end else begin
            ok = ok && (rand_w <= len);
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pokey_poly_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : pokey_poly_gen_if
// Brief    : Random-read and channel-sample bus of the poly generator.
// Revision : 1.0
// ============================================================================
interface pokey_poly_gen_if #(
    parameter int RAND_W = 8,
    parameter int NCH    = 4
);
    logic              rand_req;
    logic [RAND_W-1:0] rand_data;
    logic              rand_valid;
    logic [NCH-1:0]    chan_strobe;
    logic [NCH-1:0]    chan_bit;

    modport master (
        output rand_req,
        output chan_strobe,
        input  rand_data,
        input  rand_valid,
        input  chan_bit
    );

    modport slave (
        input  rand_req,
        input  chan_strobe,
        output rand_data,
        output rand_valid,
        output chan_bit
    );
endinterface
`default_nettype wire

// File: rtl/pokey_poly_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : pokey_poly_lfsr
// Brief    : XNOR-feedback poly register with full/short mode and init clear.
// Revision : 1.0
// ============================================================================
module pokey_poly_lfsr
    import pokey_poly_pkg::*;
#(
    parameter int             LEN       = POLY17_LEN,
    parameter int             TAP       = POLY17_TAP,
    parameter int             SHORT_EN  = 1,
    parameter int             SHORT_LEN = POLY17_SHORT_LEN,
    parameter int             SHORT_TAP = POLY17_SHORT_TAP,
    parameter logic [LEN-1:0] SEED      = POLY17_SEED,
    parameter int             RAND_W    = POLY_RAND_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              enable,
    input  logic              init,
    input  logic              mode_short,
    output logic              lsb,
    output logic [RAND_W-1:0] field
);

    localparam bit PARAMS_OK = seed_ok(64'(SEED), LEN)
                             && shape_ok(LEN, TAP, SHORT_EN, SHORT_LEN, SHORT_TAP, RAND_W);

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("pokey_poly_lfsr: illegal parameter set (all-ones SEED or bad shape)");
        end
    endgenerate

    poly_mode_e        mode_eff;
    logic [LEN-1:0]    reg_q;
    logic [LEN-1:0]    reg_d;
    logic              fb_full;
    logic              fb_short;

    assign mode_eff = (SHORT_EN != 0 && mode_short) ? MODE_SHORT : MODE_FULL;

    always_comb begin
        reg_d    = reg_q;
        fb_full  = ~(reg_q[TAP] ^ reg_q[0]) & ~init;
        fb_short = ~(reg_q[SHORT_TAP] ^ reg_q[0]) & ~init;
        if (ce && enable) begin
            // Short mode rotates only the low field; the upper bits keep their value.
            if (mode_eff == MODE_SHORT) begin
                reg_d[SHORT_LEN-1:0] = {fb_short, reg_q[SHORT_LEN-1:1]};
            end else begin
                reg_d = {fb_full, reg_q[LEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_q <= SEED;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign lsb = reg_q[0];

    generate
        if (SHORT_EN != 0) begin : g_short_field
            assign field = (mode_eff == MODE_SHORT) ? reg_q[SHORT_LEN-1 -: RAND_W]
                                                    : reg_q[LEN-1 -: RAND_W];
        end else begin : g_full_field
            assign field = reg_q[LEN-1 -: RAND_W];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pokey_poly_gen.sv
`default_nettype none
// ============================================================================
// Module   : pokey_poly_gen
// Brief    : Poly counter with random-byte capture and per-channel latches.
// Revision : 1.0
// ============================================================================
module pokey_poly_gen
    import pokey_poly_pkg::*;
#(
    parameter int             LEN       = POLY17_LEN,
    parameter int             TAP       = POLY17_TAP,
    parameter int             SHORT_EN  = 1,
    parameter int             SHORT_LEN = POLY17_SHORT_LEN,
    parameter int             SHORT_TAP = POLY17_SHORT_TAP,
    parameter logic [LEN-1:0] SEED      = POLY17_SEED,
    parameter int             RAND_W    = POLY_RAND_W,
    parameter int             NCH       = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              enable,
    input  logic              init,
    input  logic              mode_short,
    pokey_poly_gen_if.slave   bus,
    output logic              bit_out
);

    logic              lsb;
    logic [RAND_W-1:0] field;

    logic [RAND_W-1:0] rand_data_q;
    logic [RAND_W-1:0] rand_data_d;
    logic              rand_valid_q;
    logic              rand_valid_d;
    logic [NCH-1:0]    chan_bit_q;
    logic [NCH-1:0]    chan_bit_d;

    pokey_poly_lfsr #(
        .LEN       (LEN),
        .TAP       (TAP),
        .SHORT_EN  (SHORT_EN),
        .SHORT_LEN (SHORT_LEN),
        .SHORT_TAP (SHORT_TAP),
        .SEED      (SEED),
        .RAND_W    (RAND_W)
    ) u_lfsr (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .enable     (enable),
        .init       (init),
        .mode_short (mode_short),
        .lsb        (lsb),
        .field      (field)
    );

    // Capture and sampling both read the pre-shift register on the same edge.
    always_comb begin
        rand_data_d  = rand_data_q;
        rand_valid_d = ce & bus.rand_req;
        chan_bit_d   = chan_bit_q;
        if (ce && bus.rand_req) begin
            rand_data_d = ~field;
        end
        for (int i = 0; i < NCH; i++) begin
            if (ce && bus.chan_strobe[i]) begin
                chan_bit_d[i] = lsb;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rand_data_q  <= '0;
            rand_valid_q <= 1'b0;
            chan_bit_q   <= '0;
        end else begin
            rand_data_q  <= rand_data_d;
            rand_valid_q <= rand_valid_d;
            chan_bit_q   <= chan_bit_d;
        end
    end

    assign bus.rand_data  = rand_data_q;
    assign bus.rand_valid = rand_valid_q;
    assign bus.chan_bit   = chan_bit_q;
    assign bit_out        = lsb;

endmodule
`default_nettype wire

// File: tb/tb_pokey_poly_gen.sv
`default_nettype none
// Bench for pokey_poly_gen: behavioural model compared every cycle, plus
// literal checks for reset, capture, init, channel latches and periods.
module tb_pokey_poly_gen;

    localparam logic [16:0] SEED = 17'h0AAAA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n    = 1'b0;
    logic ce         = 1'b0;
    logic enable     = 1'b0;
    logic init       = 1'b0;
    logic mode_short = 1'b0;
    logic bit_out;

    logic rst4_n = 1'b0;
    logic bit4;

    pokey_poly_gen_if #(.RAND_W(8), .NCH(4)) bus ();
    pokey_poly_gen_if #(.RAND_W(2), .NCH(1)) bus4 ();

    pokey_poly_gen u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .enable     (enable),
        .init       (init),
        .mode_short (mode_short),
        .bus        (bus.slave),
        .bit_out    (bit_out)
    );

    pokey_poly_gen #(
        .LEN(4), .TAP(1), .SHORT_EN(0), .SHORT_LEN(3), .SHORT_TAP(1),
        .SEED(4'b1010), .RAND_W(2), .NCH(1)
    ) u_dut4 (
        .clk        (clk),
        .reset_n    (rst4_n),
        .ce         (1'b1),
        .enable     (1'b1),
        .init       (1'b0),
        .mode_short (1'b0),
        .bus        (bus4.slave),
        .bit_out    (bit4)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [16:0] m_reg;
    logic [7:0]  m_rdata;
    logic        m_rvalid;
    logic [3:0]  m_chan;

    function automatic logic [16:0] model_shift(input logic [16:0] r, input logic s,
                                                input logic z);
        int unsigned v, n, tap, fb, mask, field;
        v     = 32'(r);
        n     = s ? 9 : 17;
        tap   = s ? 4 : 5;
        fb    = (((v >> tap) ^ v) & 1) ^ 1;
        if (z) fb = 0;
        mask  = (1 << n) - 1;
        field = ((v & mask) >> 1) | (fb << (n - 1));
        return 17'((v & ~mask) | field);
    endfunction

    function automatic logic [7:0] model_rand(input logic [16:0] r, input logic s);
        int unsigned top;
        top = s ? 9 : 17;
        return 8'(~(32'(r) >> (top - 8)));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reg    <= SEED;
            m_rdata  <= 8'h00;
            m_rvalid <= 1'b0;
            m_chan   <= 4'h0;
        end else begin
            m_rvalid <= ce && bus.rand_req;
            if (ce && bus.rand_req) m_rdata <= model_rand(m_reg, mode_short);
            if (ce) m_chan <= (m_chan & ~bus.chan_strobe) | (bus.chan_strobe & {4{m_reg[0]}});
            if (ce && enable) m_reg <= model_shift(m_reg, mode_short, init);
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_bit_out", 32'(bit_out), 32'(m_reg[0]));
            chk("cyc_rand_valid", 32'(bus.rand_valid), 32'(m_rvalid));
            chk("cyc_rand_data", 32'(bus.rand_data), 32'(m_rdata));
            chk("cyc_chan_bit", 32'(bus.chan_bit), 32'(m_chan));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        ce              = 1'b0;
        enable          = 1'b0;
        init            = 1'b0;
        mode_short      = 1'b0;
        bus.rand_req    = 1'b0;
        bus.chan_strobe = 4'h0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        bit found;
        logic [4:0] exp4;

        bus.rand_req     = 1'b0;
        bus.chan_strobe  = 4'h0;
        bus4.rand_req    = 1'b0;
        bus4.chan_strobe = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_bit_out", 32'(bit_out), 32'd0);
        chk("rst_rand_data", 32'(bus.rand_data), 32'd0);
        chk("rst_rand_valid", 32'(bus.rand_valid), 32'd0);
        chk("rst_chan_bit", 32'(bus.chan_bit), 32'd0);
        chk("rst_reg", 32'(u_dut.u_lfsr.reg_q), 32'(SEED));
        reset_n = 1'b1;
        cmp_on  = 1'b1;

        // Random capture straight after reset
        ce = 1'b1;
        bus.rand_req = 1'b1;
        tick();
        bus.rand_req = 1'b0;
        chk("cap_valid", 32'(bus.rand_valid), 32'd1);
        chk("cap_data", 32'(bus.rand_data), 32'hAA);
        tick();
        chk("cap_valid_drop", 32'(bus.rand_valid), 32'd0);
        chk("cap_data_hold", 32'(bus.rand_data), 32'hAA);

        // Reset while rand_valid is high
        bus.rand_req = 1'b1;
        tick();
        bus.rand_req = 1'b0;
        chk("cap2_valid", 32'(bus.rand_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.rand_valid), 32'd0);
        chk("async_data", 32'(bus.rand_data), 32'd0);
        tick();
        reset_n = 1'b1;

        // Channel latches
        ce = 1'b1;
        enable = 1'b1;
        n = 0;
        while (m_reg[0] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("chan_setup_bit", 32'(bit_out), 32'd1);
        bus.chan_strobe = 4'b0101;
        tick();
        chk("chan_0101", 32'(bus.chan_bit), 32'h5);
        ce = 1'b0;
        bus.chan_strobe = 4'b1111;
        tick();
        chk("chan_ce0_hold", 32'(bus.chan_bit), 32'h5);
        bus.chan_strobe = 4'h0;
        ce = 1'b1;

        // Init clear and release
        do_reset();
        ce = 1'b1;
        enable = 1'b1;
        init = 1'b1;
        repeat (17) tick();
        chk("init_zero", 32'(u_dut.u_lfsr.reg_q), 32'd0);
        init = 1'b0;
        tick();
        chk("init_release", 32'(u_dut.u_lfsr.reg_q), 32'h10000);

        // Reset in the middle of an init sequence
        init = 1'b1;
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        chk("midinit_reg", 32'(u_dut.u_lfsr.reg_q), 32'(SEED));
        chk("midinit_bit", 32'(bit_out), 32'd0);
        chk("midinit_chan", 32'(bus.chan_bit), 32'd0);
        tick();
        reset_n = 1'b1;
        init = 1'b0;
        repeat (3) tick();

        // Short-mode period
        do_reset();
        ce = 1'b1;
        enable = 1'b1;
        mode_short = 1'b1;
        n = 0;
        found = 1'b0;
        while (!found && n < 600) begin
            tick();
            n++;
            if (u_dut.u_lfsr.reg_q == SEED) found = 1'b1;
        end
        chk("short_period", 32'(n), 32'd511);
        chk("short_upper_hold", 32'(u_dut.u_lfsr.reg_q[16:9]), 32'h55);

        // LEN=4 instance: sequence and period
        exp4 = 5'b00101;
        rst4_n = 1'b1;
        n = 0;
        found = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k <= 5) chk("len4_seq", 32'(bit4), 32'(exp4[k-1]));
            if (!found && u_dut4.u_lfsr.reg_q == 4'b1010) begin
                found = 1'b1;
                n = k;
            end
        end
        chk("len4_period", 32'(n), 32'd15);
        rst4_n = 1'b0;

        // Randomised run against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            ce              = ($urandom_range(0, 3) != 0);
            enable          = ($urandom_range(0, 3) != 0);
            init            = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) mode_short = ~mode_short;
            bus.rand_req    = ($urandom_range(0, 2) == 0);
            bus.chan_strobe = 4'($urandom);
            tick();
        end
        bus.rand_req    = 1'b0;
        bus.chan_strobe = 4'h0;
        tick();

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pokey_poly_gen.md
# pokey_poly_gen

Parametrised POKEY polynomial-counter generator: one XNOR-feedback LFSR of configurable length with an optional short mode (17/9-bit style), an init clear, a captured random-byte read port with a valid pulse, and NCH per-channel sample latches for the audio channel timers. One instance per poly (4, 5, 9/17) in the POKEY core replaces the fixed-length poly blocks. Clock-enable driven; all state updates occur only on clk edges with ce=1.

## Interface
- LEN, 17: full register length, 4..32
- TAP, 5: feedback tap in full mode; feedback = reg[TAP] XNOR reg[0]
- SHORT_EN, 1: 1 enables short mode; 0 ties mode_short internally to 0
- SHORT_LEN, 9: short-mode length, 2..LEN-1
- SHORT_TAP, 4: short-mode tap, < SHORT_LEN-1
- SEED, 17'h0AAAA: reset value, LEN bits, never all-ones
- RAND_W, 8: random read width, <= SHORT_LEN when SHORT_EN=1, else <= LEN
- NCH, 4: number of channel sample latches
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- ce  in  1  clock enable; gates every state change
- enable  in  1  shift enable
- init  in  1  forces feedback bit to 0 while high
- mode_short  in  1  1 = short mode
- rand_req  in  1  random capture request
- chan_strobe  in  NCH  per-channel sample strobes
- bit_out  out  1  reg[0]
- rand_data  out  RAND_W  captured random value
- rand_valid  out  1  one-cycle capture pulse
- chan_bit  out  NCH  latched poly bit per channel

## Operation
- Reset: reg=SEED, bit_out=SEED[0], rand_data=0, rand_valid=0, chan_bit=0.
- Full-mode shift (ce&enable, mode_short=0): reg <= {fb, reg[LEN-1:1]}, fb = (reg[TAP] XNOR reg[0]) & ~init.
- Short-mode shift (ce&enable, mode_short=1): reg[SHORT_LEN-1:0] <= {fbs, reg[SHORT_LEN-1:1]}, fbs = (reg[SHORT_TAP] XNOR reg[0]) & ~init; reg[LEN-1:SHORT_LEN] holds.
- enable=0 or ce=0: reg holds.
- init=1 with enable: zeros shift in; after LEN (short: SHORT_LEN) enabled cycles the active field is all-zero. Release continues from that state (all-zero is a valid XNOR state). init without enable: no effect.
- Mode change takes effect on the next enabled shift; no clear, no reseed.
- Random capture (ce&rand_req): rand_data <= ~reg[top-1 : top-RAND_W], top = LEN (full) or SHORT_LEN (short), using the pre-shift register value; rand_valid=1 for that following cycle only. rand_data holds until next capture. Back-to-back requests give one capture and one pulse per request.
- Channel sample (ce&chan_strobe[i]): chan_bit[i] <= reg[0] pre-shift; other channels hold. All strobes may fire together.

## Timing
- bit_out is registered reg[0]: changes the cycle after an enabled ce edge.
- rand_valid: asserted the cycle after the ce edge that sampled rand_req; deasserted next clk regardless of ce.
- chan_bit: one-cycle latency from strobe edge.
- Shift, capture, and sample on the same edge all observe the pre-shift reg.
- reset_n low mid-operation: immediate return to reset values; rand_valid clears asynchronously.
- Period with init=0 from SEED: 2^LEN-1 for maximal TAP (LEN=4,TAP=1: 15; LEN=17,TAP=5: 131071; short 9/4: 511).

## Structure
- Package pokey_poly_pkg: default constants for the POKEY polys (POLY4: LEN 4/TAP 1/SEED 4'b1010; POLY5: LEN 5/TAP 2; POLY17: LEN 17/TAP 5, SHORT 9/4), and a localparam-level check function rejecting all-ones SEED.
- Sub-module pokey_poly_lfsr: register, mode mux, feedback, init; top adds random capture and channel latches.

## Test plan
- LEN=4,TAP=1,SEED=1010, enable=1, ce every cycle: bit_out 0 after reset, then 1,0,1,0,0; period exactly 15.
- Default params, full mode, init=0: reg returns to SEED after 131071 enabled shifts, not earlier; mode_short=1 from reset: period 511, reg[16:9] constant.
- init=1 for 17 enabled cycles -> reg=0; release -> next shifted-in bit 1.
- rand_req pulse after reset (default params, full mode) -> next cycle rand_valid=1, rand_data=~SEED[16:9]=8'hAA; rand_valid 0 the cycle after.
- chan_strobe=4'b0101 with shift on same edge, reg[0]=1 -> chan_bit=4'b0101; ce=0 with strobes -> no change.
- reset_n asserted during rand_valid and mid-init -> all outputs at reset values immediately; sequence restarts from SEED.
